// File: rtl/bf16_to_bcd.sv
// Converts a bf16 value to 5 integer + 2 fraction BCD digits via sequential double-dabble.
// Define BF16_SIGNED_EN to pass negative operands through with a sign output.
module bf16_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bf16,
  input  logic        err_in,
  output logic [19:0] int_bcd,
  output logic [7:0]  frac_bcd,
  output logic        sign,
  output logic        overflow,
  output logic        error,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, UNPACK, SCALE, DINT, DFRAC, DONE} state_t;
  typedef enum logic [1:0] {C_NORM, C_ZERO, C_OVF, C_ERR} cls_t;

  state_t      state;
  cls_t        cls;
  cls_t        cls_next;
  logic [15:0] op;
  logic        op_err;
  logic [4:0]  cnt;
  logic [15:0] bin;
  logic [19:0] bcd_int;
  logic [6:0]  fbin;
  logic [7:0]  bcd_frac;

  logic [7:0]  ex;
  logic [6:0]  mant;
  logic        neg;
  logic [23:0] mant24;
  logic [23:0] fix;
  logic [6:0]  fdec;
  logic [35:0] int_step;
  logic [14:0] frac_step;

  function automatic logic [19:0] adj5(input logic [19:0] d);
    logic [19:0] r;
    r = d;
    for (int i = 0; i < 5; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] adj2(input logic [7:0] d);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < 2; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  assign ex   = op[14:7];
  assign mant = op[6:0];

`ifdef BF16_SIGNED_EN
  assign neg = op[15];
`else
  assign neg = 1'b0;
`endif

  always_comb begin
    cls_next = C_NORM;
    if (op_err || ex == 8'hFF)
      cls_next = C_ERR;
`ifndef BF16_SIGNED_EN
    else if (op[15] && ex != 8'd0)
      cls_next = C_ERR;
`endif
    else if (ex < 8'd119)
      cls_next = C_ZERO;
    else if (ex > 8'd142)
      cls_next = C_OVF;
  end

  // fix holds the value scaled by 256: integer in [23:8], binary fraction in [7:0]
  assign mant24 = {16'd0, 1'b1, mant};
  always_comb begin
    if (ex >= 8'd126)
      fix = mant24 << (ex - 8'd126);
    else
      fix = mant24 >> (8'd126 - ex);
  end

  assign fdec      = 7'(({7'd0, fix[7:0]} * 15'd100) >> 8);
  assign int_step  = {adj5(bcd_int), bin} << 1;
  assign frac_step = {adj2(bcd_frac), fbin} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cls      <= C_NORM;
      op       <= 16'd0;
      op_err   <= 1'b0;
      cnt      <= 5'd0;
      bin      <= 16'd0;
      bcd_int  <= 20'd0;
      fbin     <= 7'd0;
      bcd_frac <= 8'd0;
      int_bcd  <= 20'd0;
      frac_bcd <= 8'd0;
      sign     <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op     <= bf16;
            op_err <= err_in;
            state  <= UNPACK;
          end
        end
        UNPACK: begin
          cls   <= cls_next;
          state <= SCALE;
        end
        SCALE: begin
          case (cls)
            C_NORM: begin
              bin      <= fix[23:8];
              fbin     <= fdec;
              bcd_int  <= 20'd0;
              bcd_frac <= 8'd0;
              cnt      <= 5'd0;
              state    <= DINT;
            end
            C_ERR: begin
              int_bcd  <= 20'd0;
              frac_bcd <= 8'd0;
              sign     <= 1'b0;
              overflow <= 1'b0;
              error    <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end
            C_ZERO: begin
              int_bcd  <= 20'd0;
              frac_bcd <= 8'd0;
              sign     <= 1'b0;
              overflow <= 1'b0;
              error    <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
            default: begin
              int_bcd  <= 20'h99999;
              frac_bcd <= 8'h99;
              sign     <= neg;
              overflow <= 1'b1;
              error    <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          endcase
        end
        DINT: begin
          {bcd_int, bin} <= int_step;
          if (cnt == 5'd15) begin
            cnt   <= 5'd0;
            state <= DFRAC;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DFRAC: begin
          {bcd_frac, fbin} <= frac_step;
          if (cnt == 5'd6) begin
            // publish every output on the same edge so no partial result is seen
            cnt      <= 5'd0;
            int_bcd  <= bcd_int;
            frac_bcd <= frac_step[14:7];
            sign     <= neg;
            overflow <= 1'b0;
            error    <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
